// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_e;

   localparam logic [4:0]  ZERO_REG = 5'd31;
   localparam int unsigned PERF_W   = 32;

endpackage

// File: rtl/hazard_cmp.sv
// Combinational load-use and CBZ hazard detection; X31 never acts as a producer.
module hazard_cmp
   import pipe_hazard_pkg::*;
(
   input  logic [4:0] id_rn,
   input  logic [4:0] id_rb,
   input  logic       id_uses_rn,
   input  logic       id_uses_rb,
   input  logic       id_is_cbz,
   input  logic       ex_regwrite,
   input  logic       ex_read_en,
   input  logic [4:0] ex_rd,
   input  logic       mem_regwrite,
   input  logic [4:0] mem_rd,
   input  logic       wb_regwrite,
   input  logic [4:0] wb_rd,
   output logic       lu,
   output logic       cz
);

   always_comb begin
      lu = ex_read_en && (ex_rd != ZERO_REG) &&
           ((id_uses_rn && (ex_rd == id_rn)) || (id_uses_rb && (ex_rd == id_rb)));
      // CBZ tests the raw register file value, so any pending writer stalls it
      cz = id_is_cbz && (id_rb != ZERO_REG) &&
           ((ex_regwrite  && (ex_rd  == id_rb)) ||
            (mem_regwrite && (mem_rd == id_rb)) ||
            (wb_regwrite  && (wb_rd  == id_rb)));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble controller with memory-wait timeout.
// Optional perf counters enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
   import pipe_hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] id_rn,
   input  logic [4:0] id_rb,
   input  logic       id_uses_rn,
   input  logic       id_uses_rb,
   input  logic       id_is_cbz,
   input  logic       ex_regwrite,
   input  logic       ex_read_en,
   input  logic [4:0] ex_rd,
   input  logic [4:0] mem_rd,
   input  logic [4:0] wb_rd,
   input  logic       mem_regwrite,
   input  logic       wb_regwrite,
   input  logic       mem_access,
   input  logic       dmem_ready,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       idex_bubble,
   output logic       back_en,
   output logic       mem_timeout,
   output logic [1:0] state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,output logic [31:0] stall_cycles,
   output logic [31:0] wait_cycles
`endif
);

   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt;
   logic             lu, cz, mem_stall, timeout_hit;

   hazard_cmp u_hazard_cmp (
      .id_rn        (id_rn),
      .id_rb        (id_rb),
      .id_uses_rn   (id_uses_rn),
      .id_uses_rb   (id_uses_rb),
      .id_is_cbz    (id_is_cbz),
      .ex_regwrite  (ex_regwrite),
      .ex_read_en   (ex_read_en),
      .ex_rd        (ex_rd),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .lu           (lu),
      .cz           (cz)
   );

   assign mem_stall   = mem_access && !dmem_ready;
   assign timeout_hit = (state_q == MEM_WAIT) && !dmem_ready && (wait_cnt == CNT_LAST);
   assign state       = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:      if (mem_stall) state_d = MEM_WAIT;
         MEM_WAIT: begin
            if (dmem_ready)       state_d = RUN;
            else if (timeout_hit) state_d = HALT;
         end
         HALT:     state_d = HALT;
         default:  state_d = RUN;
      endcase
   end

   // Hazard rules apply in RUN without a wait and on the cycle a wait completes
   always_comb begin
      logic go;
      go          = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b0;
      back_en     = 1'b0;
      case (state_q)
         RUN:      go = !mem_stall;
         MEM_WAIT: go = dmem_ready;
         default:  go = 1'b0;
      endcase
      if (go) begin
         back_en = 1'b1;
         if (lu || cz) begin
            idex_bubble = 1'b1;
         end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         if (state_q == RUN && mem_stall) wait_cnt <= '0;
         else if (state_q == MEM_WAIT && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
         if (timeout_hit) mem_timeout <= 1'b1;
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [PERF_W-1:0] stall_q, wait_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         wait_q  <= '0;
      end else begin
         if (idex_bubble && stall_q != '1)           stall_q <= stall_q + 1'b1;
         if (state_q == MEM_WAIT && wait_q != '1)    wait_q  <= wait_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
   assign wait_cycles  = wait_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int MT = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rn, id_rb, ex_rd, mem_rd, wb_rd;
   logic       id_uses_rn, id_uses_rb, id_is_cbz;
   logic       ex_regwrite, ex_read_en, mem_regwrite, wb_regwrite;
   logic       mem_access, dmem_ready;
   logic       pc_en, ifid_en, idex_bubble, back_en, mem_timeout;
   logic [1:0] state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cycles, wait_cycles;
`endif

   int vectors = 0;
   int fails   = 0;

   int     m_state;
   int     m_waited;
   bit     m_to;
   longint m_stall, m_wait;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_rn        (id_rn),
      .id_rb        (id_rb),
      .id_uses_rn   (id_uses_rn),
      .id_uses_rb   (id_uses_rb),
      .id_is_cbz    (id_is_cbz),
      .ex_regwrite  (ex_regwrite),
      .ex_read_en   (ex_read_en),
      .ex_rd        (ex_rd),
      .mem_rd       (mem_rd),
      .wb_rd        (wb_rd),
      .mem_regwrite (mem_regwrite),
      .wb_regwrite  (wb_regwrite),
      .mem_access   (mem_access),
      .dmem_ready   (dmem_ready),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .idex_bubble  (idex_bubble),
      .back_en      (back_en),
      .mem_timeout  (mem_timeout),
      .state        (state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
     ,.stall_cycles (stall_cycles),
      .wait_cycles  (wait_cycles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_hazard();
      int prod_rd[3];
      bit prod_wr[3];
      bit lu, cz;
      prod_rd = '{int'(ex_rd), int'(mem_rd), int'(wb_rd)};
      prod_wr = '{ex_regwrite, mem_regwrite, wb_regwrite};
      lu = ex_read_en && ex_rd != 31 &&
           ((id_uses_rn && ex_rd == id_rn) || (id_uses_rb && ex_rd == id_rb));
      cz = 1'b0;
      if (id_is_cbz && id_rb != 31)
         foreach (prod_rd[i]) if (prod_wr[i] && prod_rd[i] == int'(id_rb)) cz = 1'b1;
      return lu || cz;
   endfunction

   task automatic model_reset();
      m_state = 0; m_waited = 0; m_to = 0; m_stall = 0; m_wait = 0;
   endtask

   task automatic chk_state();
      chk("state", 32'(state), 32'(m_state));
      chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk("stall_cycles", stall_cycles, 32'(m_stall));
      chk("wait_cycles", wait_cycles, 32'(m_wait));
`endif
   endtask

   // Inputs must already be applied; checks near mid-cycle, then advances a clock.
   task automatic step();
      bit flow, hz;
      bit [3:0] e;
      #4;
      hz   = model_hazard();
      flow = (m_state == 0 && !(mem_access && !dmem_ready)) || (m_state == 1 && dmem_ready);
      e    = !flow ? 4'b0000 : (hz ? 4'b0011 : 4'b1101);
      chk("pc_en",       32'(pc_en),       32'(e[3]));
      chk("ifid_en",     32'(ifid_en),     32'(e[2]));
      chk("idex_bubble", 32'(idex_bubble), 32'(e[1]));
      chk("back_en",     32'(back_en),     32'(e[0]));
      chk_state();
      if (e[1]) m_stall++;
      if (m_state == 1) m_wait++;
      case (m_state)
         0: if (mem_access && !dmem_ready) begin m_state = 1; m_waited = 0; end
         1: begin
            m_waited++;
            if (dmem_ready) m_state = 0;
            else if (m_waited >= MT) begin m_state = 2; m_to = 1; end
         end
         default: ;
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      id_rn = 0; id_rb = 0; id_uses_rn = 0; id_uses_rb = 0; id_is_cbz = 0;
      ex_regwrite = 0; ex_read_en = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
      mem_regwrite = 0; wb_regwrite = 0; mem_access = 0; dmem_ready = 0;
   endtask

   function automatic logic [4:0] rreg();
      int v;
      v = $urandom_range(0, 8);
      return (v == 8) ? 5'd31 : 5'(v);
   endfunction

   initial begin
      clr();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_state();
      reset = 1'b1;

      // load-use on id_rn, then EX becomes a bubble
      ex_read_en = 1; ex_regwrite = 1; ex_rd = 3; id_rn = 3; id_uses_rn = 1;
      step();
      ex_read_en = 0; ex_regwrite = 0; ex_rd = 0;
      step();

      // X31 never a producer
      clr(); ex_read_en = 1; ex_rd = 31; id_rn = 31; id_uses_rn = 1;
      step();

      // CBZ on X5 as the producer walks EX -> MEM -> WB -> gone
      clr(); id_is_cbz = 1; id_rb = 5; id_uses_rb = 1;
      ex_regwrite = 1; ex_rd = 5;
      step();
      ex_regwrite = 0; ex_rd = 0; mem_regwrite = 1; mem_rd = 5;
      step();
      mem_regwrite = 0; mem_rd = 0; wb_regwrite = 1; wb_rd = 5;
      step();
      wb_regwrite = 0; wb_rd = 0;
      step();

      // 4 cycles of not-ready, then ready
      clr(); mem_access = 1;
      repeat (4) step();
      dmem_ready = 1;
      step();
      mem_access = 0; dmem_ready = 0;
      step();

      // load-use coinciding with a memory wait; stall lands when the wait ends
      clr(); ex_read_en = 1; ex_rd = 7; id_rb = 7; id_uses_rb = 1; mem_access = 1;
      repeat (2) step();
      dmem_ready = 1;
      step();
      clr();
      step();

      repeat (400) begin
         id_rn = rreg(); id_rb = rreg(); ex_rd = rreg(); mem_rd = rreg(); wb_rd = rreg();
         id_uses_rn = 1'($urandom); id_uses_rb = 1'($urandom);
         id_is_cbz = ($urandom_range(0, 3) == 0);
         ex_read_en = 1'($urandom); ex_regwrite = ex_read_en | 1'($urandom);
         mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
         mem_access = ($urandom_range(0, 3) == 0);
         dmem_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      // asynchronous reset in the middle of a wait
      clr(); step();
      mem_access = 1;
      repeat (3) step();
      #2 reset = 1'b0;
      #1;
      model_reset();
      chk_state();
      clr();
      @(posedge clk);
      #1 reset = 1'b1;
      step();

      // timeout into HALT, which ignores a later ready
      mem_access = 1;
      repeat (1 + MT) step();
      chk("halt_state", 32'(state), 32'd2);
      dmem_ready = 1;
      repeat (3) step();
      clr();
      step();

      reset = 1'b0;
      #1;
      model_reset();
      chk_state();
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
